// File: rtl/game_pkg.sv
// Shared definitions for the per-frame game-loop sequencer: state encoding,
// ON/OFF levels and default widths.
package game_pkg;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  localparam int DEF_N_ENEMIES   = 4;
  localparam int DEF_IDX_W       = 4;
  localparam int DEF_FRAME_W     = 16;
  localparam int DEF_TIMEOUT_CYC = 131072;
  localparam int DEF_TMO_W       = 18;

  typedef enum logic [3:0] {
    S_INIT          = 4'd0,
    S_IDLE          = 4'd1,
    S_GEN_MOVE      = 4'd2,
    S_CHECK_COLLIDE = 4'd3,
    S_LINK_ACTION   = 4'd4,
    S_MOVE_ENEMIES  = 4'd5,
    S_DRAW_MAP      = 4'd6,
    S_DRAW_LINK     = 4'd7,
    S_DRAW_ENEMY    = 4'd8,
    S_ENEMY_SEL     = 4'd9,
    S_GAME_OVER     = 4'd10
  } state_t;

  function automatic logic is_draw(input state_t s);
    return (s == S_DRAW_MAP) || (s == S_DRAW_LINK) || (s == S_DRAW_ENEMY);
  endfunction

endpackage

// File: rtl/draw_watchdog.sv
// Cycle counter bounding the time spent in one draw state; expired pulses on
// the last allowed cycle. TIMEOUT_CYC of 0 disables it.
module draw_watchdog
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int TMO_W       = DEF_TMO_W
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT_CYC == 0) begin : g_off
    assign expired = OFF;
  end else begin : g_on
    localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)     r_cnt <= '0;
      else if (clear)  r_cnt <= '0;
      else if (enable) r_cnt <= r_cnt + 1'b1;
    end

    assign expired = enable && (r_cnt == LAST);
  end

endmodule

// File: rtl/frame_sequencer.sv
// Top-level per-frame sequencer of the game loop: walks the datapath through
// move generation, collision, actions and the map/Link/enemy draw passes.
module frame_sequencer
  import game_pkg::*;
#(
  parameter int N_ENEMIES   = DEF_N_ENEMIES,
  parameter int IDX_W       = DEF_IDX_W,
  parameter int FRAME_W     = DEF_FRAME_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int TMO_W       = DEF_TMO_W
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 pause,
  input  logic                 link_dead,
  input  logic                 idle_done,
  input  logic                 draw_map_done,
  input  logic                 draw_link_done,
  input  logic                 draw_enemy_done,
  input  logic [N_ENEMIES-1:0] enemy_alive,
  output logic                 init,
  output logic                 idle,
  output logic                 gen_move,
  output logic                 check_collide,
  output logic                 apply_act_link,
  output logic                 move_enemies,
  output logic                 draw_map,
  output logic                 draw_link,
  output logic                 draw_enemy,
  output logic [IDX_W-1:0]     enemy_idx,
  output logic [FRAME_W-1:0]   frame_count,
  output logic                 game_over,
  output logic                 timeout_err
);

  localparam int PAD_W = 1 << IDX_W;

  state_t             r_state, w_next;
  logic [IDX_W-1:0]   r_enemy_idx;
  logic [FRAME_W-1:0] r_frame_count;
  logic               r_timeout_err;

  logic               w_in_draw, w_done, w_expired, w_adv, w_idx_end, w_alive_cur;
  logic [PAD_W-1:0]   w_alive_pad;

  // Padded so the scan index never selects past the vector, even at idx==N.
  assign w_alive_pad = PAD_W'(enemy_alive);
  assign w_alive_cur = w_alive_pad[r_enemy_idx];
  assign w_idx_end   = (r_enemy_idx == IDX_W'(N_ENEMIES));
  assign w_in_draw   = is_draw(r_state);

  always_comb begin
    w_done = OFF;
    case (r_state)
      S_DRAW_MAP:   w_done = draw_map_done;
      S_DRAW_LINK:  w_done = draw_link_done;
      S_DRAW_ENEMY: w_done = draw_enemy_done;
      default:      w_done = OFF;
    endcase
  end

  assign w_adv = w_done || w_expired;

  draw_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TMO_W       (TMO_W)
  ) u_wdog (
    .clock   (clock),
    .resetn  (resetn),
    .clear   (w_next != r_state),
    .enable  (w_in_draw),
    .expired (w_expired)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_INIT;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    init           = OFF;
    idle           = OFF;
    gen_move       = OFF;
    check_collide  = OFF;
    apply_act_link = OFF;
    move_enemies   = OFF;
    draw_map       = OFF;
    draw_link      = OFF;
    draw_enemy     = OFF;
    game_over      = OFF;
    case (r_state)
      S_INIT: begin
        init   = ON;
        w_next = S_DRAW_MAP;
      end
      S_IDLE: begin
        idle = ON;
        if (idle_done && !pause) w_next = S_GEN_MOVE;
      end
      S_GEN_MOVE: begin
        gen_move = ON;
        w_next   = S_CHECK_COLLIDE;
      end
      S_CHECK_COLLIDE: begin
        check_collide = ON;
        w_next        = link_dead ? S_GAME_OVER : S_LINK_ACTION;
      end
      S_LINK_ACTION: begin
        apply_act_link = ON;
        w_next         = S_MOVE_ENEMIES;
      end
      S_MOVE_ENEMIES: begin
        move_enemies = ON;
        w_next       = S_DRAW_MAP;
      end
      S_DRAW_MAP: begin
        draw_map = ON;
        if (w_adv) w_next = S_DRAW_LINK;
      end
      S_DRAW_LINK: begin
        draw_link = ON;
        if (w_adv) w_next = S_ENEMY_SEL;
      end
      S_ENEMY_SEL: begin
        if (w_idx_end)        w_next = S_IDLE;
        else if (w_alive_cur) w_next = S_DRAW_ENEMY;
      end
      S_DRAW_ENEMY: begin
        draw_enemy = ON;
        if (w_adv) w_next = S_ENEMY_SEL;
      end
      S_GAME_OVER: game_over = ON;
      default:     w_next = S_INIT;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_enemy_idx   <= '0;
      r_frame_count <= '0;
      r_timeout_err <= OFF;
    end else begin
      if (r_state == S_DRAW_LINK && w_adv)
        r_enemy_idx <= '0;
      else if (r_state == S_ENEMY_SEL && !w_idx_end && !w_alive_cur)
        r_enemy_idx <= r_enemy_idx + 1'b1;
      else if (r_state == S_DRAW_ENEMY && w_adv)
        r_enemy_idx <= r_enemy_idx + 1'b1;

      if (r_state == S_ENEMY_SEL && w_idx_end)
        r_frame_count <= r_frame_count + 1'b1;

      // A done arriving on the expiry cycle wins; only a true abort is flagged.
      if (w_in_draw && w_expired && !w_done)
        r_timeout_err <= ON;
    end
  end

  assign enemy_idx   = r_enemy_idx;
  assign frame_count = r_frame_count;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: cycle table for two frames, then
// hand sequences for pause, watchdog, frame wrap, mid-frame reset and game over.
module tb_frame_sequencer;

  localparam int P_NONE = 'h000, P_ENEMY = 'h001, P_LINK = 'h002, P_MAP = 'h004;
  localparam int P_MOVE = 'h008, P_LACT = 'h010, P_CHK = 'h020, P_GEN = 'h040;
  localparam int P_IDLE = 'h080, P_INIT = 'h100;
  localparam int A1 = 'b1010, A0 = 'b0000;

  logic       clock = 1'b0;
  logic       resetn, pause, link_dead, idle_done;
  logic       draw_map_done, draw_link_done, draw_enemy_done;
  logic [3:0] enemy_alive;
  logic       init, idle, gen_move, check_collide, apply_act_link, move_enemies;
  logic       draw_map, draw_link, draw_enemy, game_over, timeout_err;
  logic [2:0] enemy_idx;
  logic [1:0] frame_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [5:0] inp;   // {pause, idle_done, map_done, link_done, enemy_done, link_dead}
    logic [3:0] alive;
    logic [8:0] ph;
    logic       ci;
    logic [2:0] idx;
    logic [1:0] fc;
    logic       tmo;
  } vec_t;

  vec_t tbl[$];

  frame_sequencer #(
    .N_ENEMIES(4), .IDX_W(3), .FRAME_W(2), .TIMEOUT_CYC(8), .TMO_W(4)
  ) dut (
    .clock(clock), .resetn(resetn), .pause(pause), .link_dead(link_dead),
    .idle_done(idle_done), .draw_map_done(draw_map_done),
    .draw_link_done(draw_link_done), .draw_enemy_done(draw_enemy_done),
    .enemy_alive(enemy_alive), .init(init), .idle(idle), .gen_move(gen_move),
    .check_collide(check_collide), .apply_act_link(apply_act_link),
    .move_enemies(move_enemies), .draw_map(draw_map), .draw_link(draw_link),
    .draw_enemy(draw_enemy), .enemy_idx(enemy_idx), .frame_count(frame_count),
    .game_over(game_over), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  function automatic logic [8:0] ph();
    return {init, idle, gen_move, check_collide, apply_act_link, move_enemies,
            draw_map, draw_link, draw_enemy};
  endfunction

  function automatic vec_t mk(input int inp, input int al, input int p,
                              input int ci, input int ix, input int f, input int t);
    vec_t v;
    v.inp = 6'(inp); v.alive = 4'(al); v.ph = 9'(p);
    v.ci = 1'(ci); v.idx = 3'(ix); v.fc = 2'(f); v.tmo = 1'(t);
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic wait_ph(input string nm, input int p, input int budget);
    int k = 0;
    while (32'(ph()) != p && k < budget) begin
      tick();
      k++;
    end
    chk(nm, 32'(ph()), p);
  endtask

  task automatic run_frame();
    idle_done = 1'b1; draw_map_done = 1'b1; draw_link_done = 1'b1;
    tick();
    idle_done = 1'b0;
    wait_ph("frame_to_idle", P_IDLE, 30);
  endtask

  initial begin
    int nlink;
    pause = 0; link_dead = 0; idle_done = 0; enemy_alive = 4'b0;
    draw_map_done = 0; draw_link_done = 0; draw_enemy_done = 0;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #10;
    chk("reset_phase", 32'(ph()), P_INIT);
    chk("reset_regs", 32'({enemy_idx, frame_count, timeout_err, game_over}), 0);
    @(negedge clock);
    resetn = 1'b1;
    #1 chk("init_after_release", 32'(ph()), P_INIT);

    // frame 1: map done on its 5th cycle, link/enemy done on their 3rd
    tbl.push_back(mk('b000000, A1, P_MAP,   1, 0, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk('b000000, A1, P_MAP, 0, 0, 0, 0));
    tbl.push_back(mk('b001000, A1, P_LINK,  0, 0, 0, 0));
    tbl.push_back(mk('b000000, A1, P_LINK,  0, 0, 0, 0));
    tbl.push_back(mk('b000000, A1, P_LINK,  0, 0, 0, 0));
    tbl.push_back(mk('b000100, A1, P_NONE,  1, 0, 0, 0));
    tbl.push_back(mk('b000000, A1, P_NONE,  1, 1, 0, 0));
    tbl.push_back(mk('b000000, A1, P_ENEMY, 1, 1, 0, 0));
    tbl.push_back(mk('b000000, A1, P_ENEMY, 1, 1, 0, 0));
    tbl.push_back(mk('b000000, A1, P_ENEMY, 1, 1, 0, 0));
    tbl.push_back(mk('b000010, A1, P_NONE,  1, 2, 0, 0));
    tbl.push_back(mk('b000000, A1, P_NONE,  1, 3, 0, 0));
    tbl.push_back(mk('b000000, A1, P_ENEMY, 1, 3, 0, 0));
    tbl.push_back(mk('b000000, A1, P_ENEMY, 1, 3, 0, 0));
    tbl.push_back(mk('b000000, A1, P_ENEMY, 1, 3, 0, 0));
    tbl.push_back(mk('b000010, A1, P_NONE,  1, 4, 0, 0));
    tbl.push_back(mk('b000000, A1, P_IDLE,  0, 0, 1, 0));
    // frame 2: stray dones ignored, map done exactly on the expiry cycle,
    // link done held high, no enemies alive (N+1 scan cycles)
    tbl.push_back(mk('b000000, A0, P_IDLE,  0, 0, 1, 0));
    tbl.push_back(mk('b010000, A0, P_GEN,   0, 0, 1, 0));
    tbl.push_back(mk('b000000, A0, P_CHK,   0, 0, 1, 0));
    tbl.push_back(mk('b000000, A0, P_LACT,  0, 0, 1, 0));
    tbl.push_back(mk('b000000, A0, P_MOVE,  0, 0, 1, 0));
    tbl.push_back(mk('b000000, A0, P_MAP,   0, 0, 1, 0));
    for (int i = 0; i < 7; i++) tbl.push_back(mk('b000110, A0, P_MAP, 0, 0, 1, 0));
    tbl.push_back(mk('b001100, A0, P_LINK,  0, 0, 1, 0));
    tbl.push_back(mk('b000100, A0, P_NONE,  1, 0, 1, 0));
    for (int i = 1; i <= 4; i++) tbl.push_back(mk('b000000, A0, P_NONE, 1, i, 1, 0));
    tbl.push_back(mk('b000000, A0, P_IDLE,  0, 0, 2, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      {pause, idle_done, draw_map_done, draw_link_done, draw_enemy_done, link_dead} = tbl[i].inp;
      enemy_alive = tbl[i].alive;
      tick();
      chk($sformatf("row%0d", i), 32'({ph(), game_over, frame_count, timeout_err}),
          32'({tbl[i].ph, 1'b0, tbl[i].fc, tbl[i].tmo}));
      if (tbl[i].ci) chk($sformatf("row%0d_idx", i), 32'(enemy_idx), 32'(tbl[i].idx));
    end
    {pause, idle_done, draw_map_done, draw_link_done, draw_enemy_done, link_dead} = 6'b0;

    // pause: idle_done pulses are dropped, not remembered
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle_done = 1'b1; tick(); chk("pause_hold", 32'(ph()), P_IDLE);
      idle_done = 1'b0; tick(); chk("pause_hold", 32'(ph()), P_IDLE);
    end
    pause = 1'b0;
    tick(); chk("unpause_no_memory", 32'(ph()), P_IDLE);
    idle_done = 1'b1; tick(); chk("unpause_go", 32'(ph()), P_GEN);
    idle_done = 1'b0;

    // watchdog: link draw never completes
    wait_ph("to_map", P_MAP, 6);
    draw_map_done = 1'b1; tick(); draw_map_done = 1'b0;
    chk("to_link", 32'(ph()), P_LINK);
    nlink = 1;
    while (32'(ph()) == P_LINK && nlink < 20) begin
      tick();
      if (32'(ph()) == P_LINK) nlink++;
    end
    chk("link_timeout_cycles", 32'(nlink), 8);
    chk("timeout_err_set", 32'(timeout_err), 1);
    wait_ph("tmo_frame_idle", P_IDLE, 10);
    chk("fc_3", 32'(frame_count), 3);

    // frame counter wraps modulo 4; watchdog flag stays sticky
    run_frame(); chk("fc_wrap_0", 32'(frame_count), 0);
    run_frame(); chk("fc_1", 32'(frame_count), 1);
    chk("timeout_sticky", 32'(timeout_err), 1);

    // asynchronous reset in the middle of an enemy draw
    enemy_alive = 4'b0001;
    idle_done = 1'b1; tick(); idle_done = 1'b0;
    wait_ph("reach_enemy", P_ENEMY, 30);
    chk("enemy_idx0", 32'(enemy_idx), 0);
    #3 resetn = 1'b0;
    #1;
    chk("async_reset_phase", 32'(ph()), P_INIT);
    chk("async_reset_regs", 32'({enemy_idx, frame_count, timeout_err, game_over}), 0);
    enemy_alive = 4'b0;
    @(negedge clock);
    resetn = 1'b1;
    wait_ph("post_reset_idle", P_IDLE, 30);
    chk("post_reset_fc", 32'(frame_count), 1);

    // game over is terminal
    link_dead = 1'b1; idle_done = 1'b1; tick(); idle_done = 1'b0;
    tick(); chk("at_check", 32'(ph()), P_CHK);
    tick(); chk("game_over", 32'({ph(), game_over}), 32'({9'h0, 1'b1}));
    for (int i = 0; i < 8; i++) begin
      idle_done = 1'(i); pause = 1'(i >> 1); link_dead = 1'b0;
      draw_map_done = 1'b1; draw_link_done = 1'b1; draw_enemy_done = 1'b1;
      tick();
      chk("game_over_hold", 32'({ph(), game_over, frame_count}), 32'({9'h0, 1'b1, 2'd1}));
    end
    resetn = 1'b0;
    #1 chk("go_reset", 32'({ph(), game_over}), 32'({9'h100, 1'b0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Parametrised successor to the game control FSM: the top-level per-frame sequencer of the game loop.
- Steps the datapath through init, idle/frame wait, movement generation, collision check, Link action, enemy move, map draw, Link draw, then one draw pass per live enemy.
- Adds over the previous generation: a pause hold, a game-over terminal state, a sticky draw-timeout watchdog and a wrapping frame counter.
- Sits between the frame timer/user-input logic and the datapath draw engines; the VGA adapter is driven only by the datapath.

Parameters:
N_ENEMIES, 4, number of enemy slots drawn per frame (1..16)
IDX_W, 4, width of enemy_idx; must satisfy 2^IDX_W > N_ENEMIES
FRAME_W, 16, width of frame_count
TIMEOUT_CYC, 131072, max cycles in any draw state before forced abort; 0 disables the watchdog
TMO_W, 18, watchdog counter width; must satisfy 2^TMO_W > TIMEOUT_CYC

Ports:
clock  in  1  system clock (CLOCK_50); the only clock
resetn  in  1  reset, asynchronous, active-low
pause  in  1  level; holds the loop in IDLE while high
link_dead  in  1  from datapath; sampled only in S_CHECK_COLLIDE
idle_done  in  1  frame-timer tick
draw_map_done  in  1  map draw complete
draw_link_done  in  1  Link draw complete
draw_enemy_done  in  1  current enemy draw complete
enemy_alive  in  N_ENEMIES  per-slot alive flags
init, idle, gen_move, check_collide, apply_act_link, move_enemies, draw_map, draw_link, draw_enemy  out  1 each  phase enables; exactly one high per cycle except in S_ENEMY_SEL and S_GAME_OVER (all low)
enemy_idx  out  IDX_W  slot currently being drawn
frame_count  out  FRAME_W  completed frames
game_over  out  1  high in S_GAME_OVER
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Asynchronous reset (resetn low) forces:
  - state = S_INIT; init=1; all other phase enables 0.
  - enemy_idx=0, frame_count=0, watchdog counter=0, timeout_err=0, game_over=0.
- Registered state; outputs are Moore, decoded from state.
- Transitions:
  - S_INIT -> S_DRAW_MAP unconditionally. Stays one cycle after reset release.
  - S_IDLE -> S_GEN_MOVE when idle_done && !pause. While pause=1, idle_done is ignored and not remembered.
  - S_GEN_MOVE -> S_CHECK_COLLIDE. One cycle.
  - S_CHECK_COLLIDE -> S_GAME_OVER if link_dead, else S_LINK_ACTION.
  - S_LINK_ACTION -> S_MOVE_ENEMIES -> S_DRAW_MAP. One cycle each.
  - S_DRAW_MAP -> S_DRAW_LINK on draw_map_done or timeout.
  - S_DRAW_LINK -> S_ENEMY_SEL on draw_link_done or timeout; enemy_idx cleared to 0 on this transition.
  - S_ENEMY_SEL, scanning one slot per cycle:
    - enemy_idx==N_ENEMIES -> S_IDLE, frame_count+1 (wraps modulo 2^FRAME_W).
    - enemy_alive[enemy_idx] -> S_DRAW_ENEMY.
    - else enemy_idx+1, stay.
  - S_DRAW_ENEMY -> S_ENEMY_SEL with enemy_idx+1 on draw_enemy_done or timeout.
  - S_GAME_OVER is terminal until reset; all inputs are ignored.
  - Unused encodings -> S_INIT.
- Watchdog:
  - Counter clears on entry to each draw state and increments every cycle spent in it.
  - When the counter reaches TIMEOUT_CYC-1 without done, the state advances as if done had arrived and timeout_err is set.
  - timeout_err is cleared only by reset.
  - done and timeout in the same cycle counts as done; timeout_err is not set.
- Done inputs are ignored outside their own state. A done held high advances on the first cycle of its state.
- With no enemies alive, S_ENEMY_SEL takes N_ENEMIES+1 cycles, then returns to S_IDLE.
- enemy_alive is sampled per cycle in S_ENEMY_SEL. It is never latched.
- Reset asserted mid-frame aborts immediately to S_INIT. No partial frame is counted.

Decomposition:
- Shared package game_pkg holds:
  - the state encoding localparams (4-bit: S_INIT..S_GAME_OVER, S_ENEMY_SEL);
  - ON/OFF constants;
  - default widths.
- One sub-module, draw_watchdog:
  - inputs: clear, enable;
  - output: expired pulse;
  - parameters: TIMEOUT_CYC, TMO_W.
- The FSM, enemy index and frame counter stay in frame_sequencer.

Test Plan:
- Release reset, draw_map_done after 5 cycles -> init high 1 cycle, draw_map high 5 cycles, then draw_link; frame_count=0.
- Full frame, N_ENEMIES=4, enemy_alive=4'b1010, each done 3 cycles after entering its state -> draw_enemy asserted with enemy_idx=1 then 3; back to idle; frame_count=1.
- pause=1 with idle_done pulsed 3 times, then pause=0 and idle_done once -> gen_move only after the final pulse.
- link_dead=1 in S_CHECK_COLLIDE -> game_over=1 forever; all phase enables 0; idle_done and done pulses ignored until resetn low.
- TIMEOUT_CYC=8, draw_link_done never asserted -> draw_link high exactly 8 cycles, timeout_err=1 and stays 1 through later frames.
- FRAME_W=2, run 5 frames -> frame_count sequence 1,2,3,0,1; resetn low mid S_DRAW_ENEMY -> asynchronous return to init with frame_count=0.
